// File: rtl/event_hold_latch.sv
// event_hold_latch: multi-channel event capture and stretch with a one-deep per-channel queue
// Ports:
//   CLK         single clock, all state on rising edge
//   RST_N       asynchronous active-low reset
//   IN[W]       per-channel event input, sampled each edge
//   ACK[W]      per-channel release acknowledge (only used when STICKY=1)
//   CLR_MISSED  clears all MISSED bits (a same-cycle new miss wins)
//   OUT[W]      per-channel stretched event, high while the channel is not IDLE
//   MISSED[W]   sticky overflow flag, set when an event arrives with one already queued
//   BUSY        OR of OUT
// Optional: define EVENT_HOLD_EDGE_EN to count only rising edges of IN as events.
module event_hold_latch #(
  parameter int WIDTH  = 8,
  parameter int HOLD   = 4,
  parameter int STICKY = 0
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] IN,
  input  logic [WIDTH-1:0] ACK,
  input  logic             CLR_MISSED,
  output logic [WIDTH-1:0] OUT,
  output logic [WIDTH-1:0] MISSED,
  output logic             BUSY
);
  localparam int CW = $clog2(HOLD + 1);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HOLD = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  if (WIDTH < 1 || HOLD < 1) begin : g_bad_cfg
    $fatal(1, "event_hold_latch: WIDTH and HOLD must both be >= 1");
  end

  logic [WIDTH-1:0] ev;

`ifdef EVENT_HOLD_EDGE_EN
  logic [WIDTH-1:0] prev_in;
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) prev_in <= '0;
    else prev_in <= IN;
  assign ev = IN & ~prev_in;
`else
  assign ev = IN;
`endif

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    logic [1:0]    state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          pend, pend_n, miss, miss_n, idle, trig;
    always_comb begin
      idle    = state == S_IDLE;
      trig    = ev[i] | pend;
      state_n = idle ? (trig ? S_HOLD : S_IDLE) :
                state == S_HOLD ? (cnt != '0 ? S_HOLD : (STICKY != 0 ? S_WAIT : S_IDLE)) :
                ACK[i] ? S_IDLE : S_WAIT;
      cnt_n   = (idle && trig) ? CW'(HOLD - 1) : (cnt != '0 ? cnt - CW'(1) : '0);
      // Leaving IDLE consumes the queued event; a simultaneous new event re-arms the queue.
      pend_n  = idle ? (pend & ev[i]) : (pend | ev[i]);
      miss_n  = (!idle && ev[i] && pend) || (miss && !CLR_MISSED);
    end
    always_ff @(posedge CLK or negedge RST_N)
      if (!RST_N) begin
        state <= S_IDLE;
        cnt   <= '0;
        pend  <= 1'b0;
        miss  <= 1'b0;
      end else begin
        state <= state_n;
        cnt   <= cnt_n;
        pend  <= pend_n;
        miss  <= miss_n;
      end
    assign OUT[i]    = state != S_IDLE;
    assign MISSED[i] = miss;
  end

  assign BUSY = |OUT;
endmodule
